fmultp_iter: RTL and testbench

FMULTP_ITER -- requirements
Module: fmultp_iter

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_classify.sv | 22 ++
 rtl/fmultp_iter.sv | 142 ++++++++++++++
 tb/tb_fmultp_iter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, state encoding and packing helper for the iterative
// single-precision multiplier.
package fp_pkg;

  localparam logic signed [9:0] BIAS    = 10'sd127;
  localparam logic signed [9:0] EXP_MAX = 10'sd255;
  localparam logic [31:0]       QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2
  } state_t;

  function automatic logic [31:0] pack_fp(input logic s, input logic [7:0] e, input logic [22:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single operand classifier; exponent 0 counts as zero
// because denormals are not supported.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] op,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  logic exp_max_s;
  logic frac_nz_s;

  assign exp_max_s = (op[30:23] == EXP_MAX[7:0]);
  assign frac_nz_s = (op[22:0] != 23'd0);

  assign is_zero = (op[30:23] == 8'd0);
  assign is_inf  = exp_max_s & ~frac_nz_s;
  assign is_nan  = exp_max_s & frac_nz_s;

endmodule

// File: rtl/fmultp_iter.sv
// Iterative shift-add IEEE-754 single multiplier with fixed latency:
// one MUL cycle per multiplier bit, then one NORM cycle that packs the result.
module fmultp_iter
  import fp_pkg::*;
#(
  parameter int MUL_STEPS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] regb,
  input  logic [31:0] regc,
  output logic [31:0] rega,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [47:0]       acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [23:0]       mb_r;
  logic [23:0]       mc_r;
  logic signed [9:0] exp_r;
  logic              sign_r;
  logic              nan_r;
  logic              zero_r;
  logic              inf_r;

  logic              b_zero_s, b_inf_s, b_nan_s;
  logic              c_zero_s, c_inf_s, c_nan_s;
  logic signed [9:0] exp_fin_s;
  logic [22:0]       frac_s;
  logic [31:0]       result_s;
  logic              unused_s;

  fp_classify u_cls_b (.op(regb), .is_zero(b_zero_s), .is_inf(b_inf_s), .is_nan(b_nan_s));
  fp_classify u_cls_c (.op(regc), .is_zero(c_zero_s), .is_inf(c_inf_s), .is_nan(c_nan_s));

  // Truncated product bits below the kept fraction are intentionally dropped.
  assign unused_s = ^acc_r[22:0];

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      acc_r   <= 48'd0;
      cnt_r   <= '0;
      mb_r    <= 24'd0;
      mc_r    <= 24'd0;
      exp_r   <= 10'sd0;
      sign_r  <= 1'b0;
      nan_r   <= 1'b0;
      zero_r  <= 1'b0;
      inf_r   <= 1'b0;
      rega    <= 32'd0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sign_r <= regb[31] ^ regc[31];
            exp_r  <= $signed({2'b00, regb[30:23]}) + $signed({2'b00, regc[30:23]}) - BIAS;
            mb_r   <= {1'b1, regb[22:0]};
            mc_r   <= {1'b1, regc[22:0]};
            nan_r  <= b_nan_s | c_nan_s | (b_inf_s & c_zero_s) | (b_zero_s & c_inf_s);
            zero_r <= b_zero_s | c_zero_s;
            inf_r  <= b_inf_s | c_inf_s;
            acc_r  <= 48'd0;
            cnt_r  <= '0;
          end
        end
        ST_MUL: begin
          if (mc_r[cnt_r]) begin
            acc_r <= acc_r + ({24'd0, mb_r} << cnt_r);
          end
          cnt_r <= cnt_r + CNT_W'(1);
        end
        ST_NORM: begin
          rega <= result_s;
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_MUL;
        else       state_nxt_s = ST_IDLE;
      end
      ST_MUL: begin
        if (cnt_r == CNT_LAST) state_nxt_s = ST_NORM;
        else                   state_nxt_s = ST_MUL;
      end
      ST_NORM: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Status output decoded from state.
  always_comb begin
    busy = (state_r != ST_IDLE);
  end

  // Normalisation and special-case override; NaN outranks zero outranks infinity.
  always_comb begin
    exp_fin_s = exp_r;
    frac_s    = acc_r[45:23];
    result_s  = 32'd0;
    if (acc_r[47]) begin
      exp_fin_s = exp_r + 10'sd1;
      frac_s    = acc_r[46:24];
    end else begin
      exp_fin_s = exp_r;
      frac_s    = acc_r[45:23];
    end
    if (nan_r) begin
      result_s = QNAN;
    end else if (zero_r) begin
      result_s = pack_fp(sign_r, 8'd0, 23'd0);
    end else if (inf_r || (exp_fin_s >= EXP_MAX)) begin
      result_s = pack_fp(sign_r, 8'hFF, 23'd0);
    end else if (exp_fin_s <= 10'sd0) begin
      result_s = pack_fp(sign_r, 8'd0, 23'd0);
    end else begin
      result_s = pack_fp(sign_r, exp_fin_s[7:0], frac_s);
    end
  end

endmodule

// File: tb/tb_fmultp_iter.sv
// Directed self-checking bench for fmultp_iter: vector table plus busy,
// back-to-back and mid-operation reset sequences.
module tb_fmultp_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] regb;
  logic [31:0] regc;
  logic [31:0] rega;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  fmultp_iter #(.MUL_STEPS(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .regb(regb), .regc(regc),
    .rega(rega), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands with start for one rising edge; returns at the following negedge.
  task automatic start_op(input logic [31:0] b, input logic [31:0] c);
    @(negedge clk);
    regb  = b;
    regc  = c;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges from the accept edge until done is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int ndone;
    int dcyc;
    logic [31:0] dval;

    vecs[0]  = '{"2x3",       32'h40000000, 32'h40400000, 32'h40C00000};
    vecs[1]  = '{"1.5x1.5",   32'h3FC00000, 32'h3FC00000, 32'h40100000};
    vecs[2]  = '{"-2x0.5",    32'hC0000000, 32'h3F000000, 32'hBF800000};
    vecs[3]  = '{"infx0",     32'h7F800000, 32'h00000000, 32'h7FC00000};
    vecs[4]  = '{"ovf",       32'h7F000000, 32'h7F000000, 32'h7F800000};
    vecs[5]  = '{"nanx1",     32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    vecs[6]  = '{"0x-3",      32'h00000000, 32'hC0400000, 32'h80000000};
    vecs[7]  = '{"infx-2",    32'h7F800000, 32'hC0000000, 32'hFF800000};
    vecs[8]  = '{"3x5",       32'h40400000, 32'h40A00000, 32'h41700000};
    vecs[9]  = '{"1x1",       32'h3F800000, 32'h3F800000, 32'h3F800000};
    vecs[10] = '{"exp254",    32'h7F000000, 32'h3F800000, 32'h7F000000};
    vecs[11] = '{"exp1",      32'h00800000, 32'h3F800000, 32'h00800000};
    vecs[12] = '{"exp0",      32'h00800000, 32'h3F000000, 32'h00000000};
    vecs[13] = '{"udf",       32'h00800000, 32'h00800000, 32'h00000000};

    rst_n = 1'b0;
    start = 1'b0;
    regb  = 32'd0;
    regc  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rega", rega, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].b, vecs[i].c);
      check({vecs[i].name, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(cyc);
      check({vecs[i].name, "_lat"}, cyc, 32'd25);
      check({vecs[i].name, "_res"}, rega, vecs[i].exp);
      @(posedge clk);
      @(negedge clk);
      check({vecs[i].name, "_pulse"}, {31'd0, done}, 32'd0);
      check({vecs[i].name, "_idle"}, {31'd0, busy}, 32'd0);
    end

    // Start pulses with different operands while busy must be ignored.
    start_op(32'h40000000, 32'h40400000);
    ndone = 0;
    dcyc  = 0;
    dval  = 32'd0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        dcyc = i;
        dval = rega;
      end
      regb = 32'h3FC00000;
      regc = 32'hC0000000;
      start = (i == 3 || i == 10) ? 1'b1 : 1'b0;
    end
    check("busy_ndone", ndone, 32'd1);
    check("busy_lat", dcyc, 32'd25);
    check("busy_res", dval, 32'h40C00000);

    // Back-to-back: start asserted in the done cycle.
    regb  = 32'h3FC00000;
    regc  = 32'h3FC00000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(cyc);
    check("b2b_lat", cyc, 32'd25);
    check("b2b_res", rega, 32'h40100000);

    // Reset at cycle 10 of an operation aborts it.
    start_op(32'h40400000, 32'h40A00000);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_rega", rega, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    check("arst_nodone", ndone, 32'd0);
    check("arst_rega_hold", rega, 32'd0);
    start_op(32'h40400000, 32'h40A00000);
    wait_done(cyc);
    check("post_rst_lat", cyc, 32'd25);
    check("post_rst_res", rega, 32'h41700000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
